uart_cmd_parser: RTL and testbench

Byte-level command parser downstream of the UART receive module. Consumes the 9-bit received frames (8 data bits plus received parity bit), checks even parity, assembles sync/address/data/checksum sequences, and issues single register-write requests to the VGA configuration register file over a valid/ack handshake. Keeps saturating error counters for link diagnostics.

---
 rtl/uart_cmd_parser.sv | 115 +++++++++++
 tb/tb_uart_cmd_parser.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: turns parity-checked UART frames into single register-write requests
//
// Command framing: SYNC_BYTE, address, data, and (with UART_CMD_PARSER_CSUM_EN
// defined) a checksum byte equal to address ^ data. A finished command is held
// on wr_valid/wr_addr/wr_data until wr_ack. Saturating counters record link errors.
//
// Ports:
//   clk, rst (async, active-low)
//   frame_valid, frame[8:0]  received byte [7:0] plus parity bit [8], even parity
//   wr_valid, wr_addr, wr_data, wr_ack   register-write handshake
//   busy                                 parser is not IDLE
//   err_parity_cnt, err_csum_cnt, err_overrun_cnt, clr_err   error counters
//
// Configuration macro: UART_CMD_PARSER_CSUM_EN enables the checksum byte.
module uart_cmd_parser #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 4096,
  parameter int         CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_valid,
  input  logic [8:0]       frame,
  output logic             wr_valid,
  output logic [7:0]       wr_addr,
  output logic [7:0]       wr_data,
  input  logic             wr_ack,
  output logic             busy,
  output logic [CNT_W-1:0] err_parity_cnt,
  output logic [CNT_W-1:0] err_csum_cnt,
  output logic [CNT_W-1:0] err_overrun_cnt,
  input  logic             clr_err
);
  typedef enum logic [2:0] {IDLE, ADDR, DATA, CSUM, WRITE} state_t;
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  state_t        state, state_nx, st_eff;
  logic [TW-1:0] tmr;
  logic          good, take, par_err, ovr, in_cmd, tout, ld_addr, ld_data;
`ifdef UART_CMD_PARSER_CSUM_EN
  logic          csum_err;
`endif
  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c, input logic inc);
    return (inc && !(&c)) ? c + 1'b1 : c;
  endfunction
  assign good     = ~^frame;
  // A frame landing with wr_ack completes the write and is parsed as if from IDLE.
  assign take     = frame_valid && (state != WRITE || wr_ack);
  assign st_eff   = (state == WRITE) ? IDLE : state;
  assign par_err  = take && !good;
  assign ovr      = frame_valid && state == WRITE && !wr_ack;
  assign in_cmd   = state == ADDR || state == DATA || state == CSUM;
  // tmr counts idle cycles already elapsed; this cycle is idle number tmr+1.
  assign tout     = in_cmd && !frame_valid && tmr == TW'(TIMEOUT_CYCLES - 2);
  assign wr_valid = state == WRITE;
  assign busy     = state != IDLE;
  always_comb begin
    state_nx = state;
    ld_addr  = 1'b0;
    ld_data  = 1'b0;
`ifdef UART_CMD_PARSER_CSUM_EN
    csum_err = 1'b0;
`endif
    if (state == WRITE && wr_ack) state_nx = IDLE;
    if (take) begin
      if (!good) state_nx = IDLE;
      else case (st_eff)
        IDLE: state_nx = (frame[7:0] == SYNC_BYTE) ? ADDR : IDLE;
        ADDR: begin
          ld_addr  = 1'b1;
          state_nx = DATA;
        end
        DATA: begin
          ld_data  = 1'b1;
`ifdef UART_CMD_PARSER_CSUM_EN
          state_nx = CSUM;
`else
          state_nx = WRITE;
`endif
        end
`ifdef UART_CMD_PARSER_CSUM_EN
        CSUM: begin
          csum_err = frame[7:0] != (wr_addr ^ wr_data);
          state_nx = csum_err ? IDLE : WRITE;
        end
`endif
        default: state_nx = IDLE;
      endcase
    end else if (tout) state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      tmr             <= '0;
      wr_addr         <= '0;
      wr_data         <= '0;
      err_parity_cnt  <= '0;
      err_overrun_cnt <= '0;
    end else begin
      state           <= state_nx;
      tmr             <= (frame_valid || !in_cmd) ? '0 : tmr + 1'b1;
      if (ld_addr) wr_addr <= frame[7:0];
      if (ld_data) wr_data <= frame[7:0];
      err_parity_cnt  <= clr_err ? '0 : bump(err_parity_cnt, par_err);
      err_overrun_cnt <= clr_err ? '0 : bump(err_overrun_cnt, ovr);
    end
  end
`ifdef UART_CMD_PARSER_CSUM_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_csum_cnt <= '0;
    else err_csum_cnt <= clr_err ? '0 : bump(err_csum_cnt, csum_err);
  end
`else
  assign err_csum_cnt = '0;
`endif
endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser: table vectors, hand sequences and a write scoreboard for uart_cmd_parser
module tb_uart_cmd_parser;
  localparam int T = 16;
`ifdef UART_CMD_PARSER_CSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif
  logic       clk = 0, rst = 0, frame_valid = 0, wr_ack = 0, clr_err = 0;
  logic [8:0] frame = '0;
  logic       wr_valid, busy;
  logic [7:0] wr_addr, wr_data, err_parity_cnt, err_csum_cnt, err_overrun_cnt;
  int checks = 0, failures = 0, nwr = 0, exp_nwr = 0, ep = 0, ec = 0, eo = 0;
  logic [15:0] sb[$];

  uart_cmd_parser #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(T), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .frame_valid(frame_valid), .frame(frame),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .busy(busy), .err_parity_cnt(err_parity_cnt), .err_csum_cnt(err_csum_cnt),
    .err_overrun_cnt(err_overrun_cnt), .clr_err(clr_err));

  always #5 clk = ~clk;

  typedef struct {
    logic [0:5][7:0] b;
    int nb, bad, wr_at, dp, dc;
    bit wr;
    logic [7:0] ea, ed;
  } vec_t;
  vec_t v[8];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", n, a, e);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input bit bad);
    frame = {bad ? ~^b : ^b, b};
    frame_valid = 1;
    cyc();
    frame_valid = 0;
  endtask

  task automatic send_cmd(input logic [7:0] a, input logic [7:0] d);
    send(8'hA5, 0);
    send(a, 0);
    send(d, 0);
    if (CSUM) send(a ^ d, 0);
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] d);
    sb.push_back({a, d});
    exp_nwr++;
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_par"}, err_parity_cnt, ep);
    chk({tag, "_csum"}, err_csum_cnt, ec);
    chk({tag, "_ovr"}, err_overrun_cnt, eo);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_wr_valid"}, wr_valid, 0);
  endtask

  function automatic vec_t mk(logic [0:5][7:0] b, int nb, int bad, int base, bit wr,
                              logic [7:0] ea, logic [7:0] ed, int dp, int dc);
    vec_t r;
    r.b = b; r.nb = nb; r.bad = bad; r.wr = wr; r.ea = ea; r.ed = ed; r.dp = dp; r.dc = dc;
    r.wr_at = base + (CSUM ? 3 : 2);
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst && wr_valid && wr_ack) begin
      logic [15:0] e;
      nwr++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL wr_unexpected actual addr=%0h data=%0h expected no write", wr_addr, wr_data);
      end else begin
        e = sb.pop_front();
        chk("sb_wr_addr", wr_addr, e[15:8]);
        chk("sb_wr_data", wr_data, e[7:0]);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    v[0] = mk({8'hA5, 8'h0C, 8'h06, 8'h0A, 8'h00, 8'h00}, 4, -1, 0, 1, 8'h0C, 8'h06, 0, 0);
    v[1] = mk({8'hA5, 8'hD5, 8'h00, 8'h00, 8'h00, 8'h00}, 2, 1, 0, 0, 8'h00, 8'h00, 1, 0);
    v[2] = mk({8'hA5, 8'hD5, 8'h06, 8'hD3, 8'h00, 8'h00}, 4, -1, 0, 1, 8'hD5, 8'h06, 0, 0);
    v[3] = mk({8'hA5, 8'h09, 8'h01, 8'h00, 8'h00, 8'h00}, 4, -1, 0, !CSUM, 8'h09, 8'h01, 0, int'(CSUM));
    v[4] = mk({8'hA5, 8'hA5, 8'hFF, 8'h5A, 8'h00, 8'h00}, 4, -1, 0, 1, 8'hA5, 8'hFF, 0, 0);
    v[5] = mk({8'h3C, 8'hA5, 8'h10, 8'h20, 8'h30, 8'h00}, 5, -1, 1, 1, 8'h10, 8'h20, 0, 0);
    v[6] = mk({8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1, 0, 0, 0, 8'h00, 8'h00, 1, 0);
    v[7] = mk({8'hA5, 8'h11, 8'h22, 8'h33, 8'h00, 8'h00}, 4, 3, 0, !CSUM, 8'h11, 8'h22, 1, 0);

    repeat (2) cyc();
    chk_cnt("reset");
    chk("reset_addr", wr_addr, 0);
    chk("reset_data", wr_data, 0);
    rst = 1;
    wr_ack = 1;
    cyc();

    for (int i = 0; i < 8; i++) begin
      if (v[i].wr) push(v[i].ea, v[i].ed);
      for (int j = 0; j < v[i].nb; j++) begin
        send(v[i].b[j], j == v[i].bad);
        if (v[i].wr && j == v[i].wr_at) chk($sformatf("v%0d_latency", i), wr_valid, 1);
      end
      repeat (3) cyc();
      ep += v[i].dp;
      ec += v[i].dc;
      chk_cnt($sformatf("v%0d", i));
    end

    clr_err = 1;
    send(8'h01, 1);
    clr_err = 0;
    ep = 0; ec = 0; eo = 0;
    cyc();
    chk_cnt("clr_priority");

    wr_ack = 0;
    push(8'h31, 8'h42);
    send_cmd(8'h31, 8'h42);
    cyc();
    send(8'hA5, 0);
    send(8'h12, 1);
    send(8'h55, 0);
    eo = 3;
    chk("stall_valid", wr_valid, 1);
    chk("stall_addr", wr_addr, 8'h31);
    chk("stall_data", wr_data, 8'h42);
    chk("stall_ovr", err_overrun_cnt, eo);
    chk("stall_par", err_parity_cnt, ep);
    chk("stall_nwr", nwr, exp_nwr - 1);
    wr_ack = 1;
    cyc();
    wr_ack = 0;
    cyc();
    chk_cnt("stall_done");

    push(8'h44, 8'h11);
    push(8'h55, 8'h66);
    send_cmd(8'h44, 8'h11);
    cyc();
    wr_ack = 1;
    send(8'hA5, 0);
    wr_ack = 0;
    chk("ack_frame_busy", busy, 1);
    send(8'h55, 0);
    send(8'h66, 0);
    if (CSUM) send(8'h33, 0);
    chk("ack_frame_addr", wr_addr, 8'h55);
    wr_ack = 1;
    cyc();
    cyc();
    chk_cnt("ack_frame");

    push(8'h0C, 8'h06);
    send(8'hA5, 0);
    repeat (T - 2) cyc();
    chk("tmo_alive_busy", busy, 1);
    send(8'h0C, 0);
    send(8'h06, 0);
    if (CSUM) send(8'h0A, 0);
    repeat (2) cyc();
    chk_cnt("tmo_alive");
    send(8'hA5, 0);
    repeat (T) cyc();
    chk("tmo_addr_busy", busy, 0);
    send(8'h0C, 0);
    send(8'h06, 0);
    send(8'h0A, 0);
    repeat (2) cyc();
    chk_cnt("tmo_addr");
    send(8'hA5, 0);
    send(8'h77, 0);
    repeat (T) cyc();
    chk("tmo_data_busy", busy, 0);
    send(8'h01, 0);
    repeat (2) cyc();
    chk_cnt("tmo_data");

    wr_ack = 0;
    send_cmd(8'h99, 8'h88);
    send(8'h00, 0);
    eo++;
    chk("rst_pre_valid", wr_valid, 1);
    chk("rst_pre_ovr", err_overrun_cnt, eo);
    #2 rst = 0;
    #1;
    ep = 0; ec = 0; eo = 0;
    chk_cnt("rst_async");
    chk("rst_async_addr", wr_addr, 0);
    chk("rst_async_data", wr_data, 0);
    wr_ack = 1;
    @(posedge clk);
    #1 rst = 1;
    cyc();
    chk_cnt("rst_after");

    for (int i = 0; i < 260; i++) send(8'(i), 1);
    cyc();
    chk("sat_par", err_parity_cnt, 8'hFF);
    chk("sat_busy", busy, 0);

    repeat (3) cyc();
    chk("sb_empty", sb.size(), 0);
    chk("nwr_total", nwr, exp_nwr);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
